alu_share_arbiter: RTL and testbench

//  Shares one combinational WIDTH-bit ALU (a ripple of 1-bit and/or/add/sub/slt

---
 rtl/alu_share_arbiter.sv | 101 ++++++++++
 tb/tb_alu_share_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// One operation in flight: grant (IDLE) -> drive registered operands (EXEC) -> hold response (RESP).
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [2:0]       req_sel0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [2:0]       req_sel1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  state_t           state_next;
  logic             rr;
  logic             op_id;
  logic             grant_en;
  logic             grant_id;
  logic             op_illegal;
  logic [WIDTH-1:0] exec_data;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req_valid) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Contention goes to rr; otherwise the lone valid requester (bit 1 picks requester 1).
  always_comb begin
    grant_en  = (state == IDLE) && (|req_valid);
    grant_id  = (req_valid == 2'b11) ? rr : req_valid[1];
    req_ready = 2'b00;
    if (grant_en) req_ready = grant_id ? 2'b10 : 2'b01;
    busy      = (state != IDLE);
  end

  always_comb begin
    op_illegal = (alu_sel == 3'b011) || (alu_sel == 3'b100) || (alu_sel == 3'b101);
    exec_data  = op_illegal ? '0 : alu_result;
  end

  // The op registers double as the ALU operand outputs and keep their value outside EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      op_id     <= 1'b0;
      rr        <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      if (grant_en) begin
        alu_a   <= grant_id ? req_a1   : req_a0;
        alu_b   <= grant_id ? req_b1   : req_b0;
        alu_sel <= grant_id ? req_sel1 : req_sel0;
        op_id   <= grant_id;
        rr      <= ~grant_id;
      end
      if (state == EXEC) begin
        rsp_data  <= exec_data;
        rsp_zero  <= (exec_data == '0);
        rsp_err   <= op_illegal;
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end
      if ((state == RESP) && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU on the shared port, scoreboard of expected
// responses pushed when a request is driven and popped when the response appears.
module tb_alu_share_arbiter;
  localparam int WIDTH = 32;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0]       req_sel0, req_sel1;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [2:0]       alu_sel;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
  logic [WIDTH-1:0] rsp_data;

  exp_t exp_q[$];
  exp_t e;
  int   passed = 0;
  int   total  = 0;

  alu_share_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_sel0(req_sel0),
    .req_a1(req_a1), .req_b1(req_b1), .req_sel1(req_sel1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Illegal codes yield a guaranteed non-zero value so the block's zeroing is visible.
  function automatic logic [WIDTH-1:0] ref_alu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [2:0] sel);
    case (sel)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: return (a ^ b) | 1;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [2:0] sel);
    return (sel == 3'b011) || (sel == 3'b100) || (sel == 3'b101);
  endfunction

  assign alu_result = ref_alu(alu_a, alu_b, alu_sel);

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2:0] sel);
    exp_t x;
    x.id   = id;
    x.err  = is_illegal(sel);
    x.data = x.err ? '0 : ref_alu(a, b, sel);
    x.zero = (x.data == '0);
    exp_q.push_back(x);
  endtask

  task automatic drive_req(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [2:0] sel);
    if (id) begin req_a1 = a; req_b1 = b; req_sel1 = sel; req_valid = 2'b10; end
    else    begin req_a0 = a; req_b0 = b; req_sel0 = sel; req_valid = 2'b01; end
    push_exp(id, a, b, sel);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    req_a0 = '0; req_b0 = '0; req_sel0 = '0; req_a1 = '0; req_b1 = '0; req_sel1 = '0;
    step(); step();
    rst = 1'b0;
    #1;
    total++;
    if ({busy, req_ready, rsp_valid} !== 4'b0)
      $display("[TB] FAIL reset_ctrl: got %b expected 0000", {busy, req_ready, rsp_valid});
    else passed++;
    total++;
    if ({alu_a, alu_b, alu_sel} !== '0)
      $display("[TB] FAIL reset_alu_regs: got %h/%h/%b expected all 0", alu_a, alu_b, alu_sel);
    else passed++;
    total++;
    if ({rsp_id, rsp_data, rsp_zero, rsp_err} !== '0)
      $display("[TB] FAIL reset_rsp: got id=%b data=%h z=%b e=%b expected all 0",
               rsp_id, rsp_data, rsp_zero, rsp_err);
    else passed++;
  endtask

  task automatic test_single_add();
    drive_req(1'b0, 5, 7, 3'b010);
    #1;
    total++;
    if (req_ready !== 2'b01) $display("[TB] FAIL add_grant: got %b expected 01", req_ready);
    else passed++;
    step();
    req_valid = 2'b00;
    #1;
    total++;
    if ({busy, req_ready, alu_a, alu_b, alu_sel} !== {1'b1, 2'b00, 32'd5, 32'd7, 3'b010})
      $display("[TB] FAIL add_exec: got busy=%b ready=%b a=%h b=%h sel=%b expected 1 00 5 7 010",
               busy, req_ready, alu_a, alu_b, alu_sel);
    else passed++;
    step();
    #1;
    e = exp_q.pop_front();
    total++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err} !== {1'b1, e})
      $display("[TB] FAIL add_rsp: got v=%b id=%b data=%h z=%b e=%b expected 1 %b %h %b %b",
               rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, e.id, e.data, e.zero, e.err);
    else passed++;
    step();
    #1;
    total++;
    if ({rsp_valid, busy} !== 2'b00) $display("[TB] FAIL add_done: got %b expected 00", {rsp_valid, busy});
    else passed++;
  endtask

  task automatic test_sub_backpressure();
    rsp_ready = 1'b0;
    drive_req(1'b1, 9, 9, 3'b110);
    #1;
    total++;
    if (req_ready !== 2'b10) $display("[TB] FAIL sub_grant: got %b expected 10", req_ready);
    else passed++;
    step();
    req_valid = 2'b00;
    step();
    #1;
    e = exp_q.pop_front();
    total++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err} !== {1'b1, e})
      $display("[TB] FAIL sub_rsp: got v=%b id=%b data=%h z=%b e=%b expected 1 %b %h %b %b",
               rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, e.id, e.data, e.zero, e.err);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      req_valid = (i == 1) ? 2'b01 : 2'b00;
      #1;
      total++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err} !== {1'b1, e})
        $display("[TB] FAIL sub_hold: got v=%b id=%b data=%h z=%b expected held 1 %b %h %b",
                 rsp_valid, rsp_id, rsp_data, rsp_zero, e.id, e.data, e.zero);
      else passed++;
      total++;
      if (req_ready !== 2'b00) $display("[TB] FAIL sub_no_grant_in_resp: got %b expected 00", req_ready);
      else passed++;
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    step();
    #1;
    total++;
    if ({rsp_valid, busy} !== 2'b00) $display("[TB] FAIL sub_release: got %b expected 00", {rsp_valid, busy});
    else passed++;
  endtask

  task automatic test_contention();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_a0 = 100; req_b0 = 23; req_sel0 = 3'b010;
    req_a1 = 32'h0000_F0F0; req_b1 = 32'h0000_0F01; req_sel1 = 3'b001;
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (req_ready !== ((i % 2 == 1) ? 2'b10 : 2'b01))
        $display("[TB] FAIL rr_grant%0d: got %b expected %b", i, req_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
      else passed++;
      if (i % 2 == 1) push_exp(1'b1, req_a1, req_b1, req_sel1);
      else            push_exp(1'b0, req_a0, req_b0, req_sel0);
      step();
      if (i % 2 == 1) req_a1 = req_a1 + 1;
      else            req_a0 = req_a0 + 1;
      #1;
      total++;
      if ({busy, req_ready} !== 3'b100) $display("[TB] FAIL rr_exec%0d: got %b expected 100", i, {busy, req_ready});
      else passed++;
      step();
      #1;
      e = exp_q.pop_front();
      total++;
      if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err} !== {2'b00, 1'b1, e})
        $display("[TB] FAIL rr_rsp%0d: got ready=%b v=%b id=%b data=%h z=%b e=%b expected 00 1 %b %h %b %b",
                 i, req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, e.id, e.data, e.zero, e.err);
      else passed++;
      step();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_illegal();
    logic [2:0]       sels [5] = '{3'b101, 3'b011, 3'b000, 3'b100, 3'b001};
    logic [WIDTH-1:0] as   [5] = '{32'h55, 32'h1234, 32'hF0, 32'h0, 32'hF0};
    logic [WIDTH-1:0] bs   [5] = '{32'h0F, 32'h1234, 32'h0F, 32'h0, 32'h0F};
    for (int i = 0; i < 5; i++) begin
      drive_req(1'b0, as[i], bs[i], sels[i]);
      step();
      req_valid = 2'b00;
      step();
      #1;
      e = exp_q.pop_front();
      total++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err} !== {1'b1, e})
        $display("[TB] FAIL illegal_sel%b: got v=%b data=%h z=%b e=%b expected 1 %h %b %b",
                 sels[i], rsp_valid, rsp_data, rsp_zero, rsp_err, e.data, e.zero, e.err);
      else passed++;
      step();
    end
  endtask

  task automatic test_slt();
    logic [WIDTH-1:0] as [3] = '{32'hFFFF_FFFE, 32'd3, 32'h8000_0000};
    logic [WIDTH-1:0] bs [3] = '{32'd3, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b0, as[i], bs[i], 3'b111);
      step();
      req_valid = 2'b00;
      step();
      #1;
      e = exp_q.pop_front();
      total++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err} !== {1'b1, e})
        $display("[TB] FAIL slt%0d: got v=%b data=%h z=%b e=%b expected 1 %h %b %b",
                 i, rsp_valid, rsp_data, rsp_zero, rsp_err, e.data, e.zero, e.err);
      else passed++;
      step();
    end
  endtask

  task automatic test_reset_exec();
    req_a0 = 32'h11; req_b0 = 32'h22; req_sel0 = 3'b010; req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    total++;
    if ({rsp_valid, busy, alu_a, alu_sel} !== '0)
      $display("[TB] FAIL rstx_abort: got v=%b busy=%b a=%h sel=%b expected all 0", rsp_valid, busy, alu_a, alu_sel);
    else passed++;
    req_a1 = 32'h40; req_b1 = 32'h2; req_sel1 = 3'b110;
    req_valid = 2'b11;
    push_exp(1'b0, req_a0, req_b0, req_sel0);
    #1;
    total++;
    if (req_ready !== 2'b01) $display("[TB] FAIL rstx_rr_cleared: got %b expected 01", req_ready);
    else passed++;
    step();
    req_valid = 2'b00;
    step();
    #1;
    e = exp_q.pop_front();
    total++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err} !== {1'b1, e})
      $display("[TB] FAIL rstx_rsp: got v=%b id=%b data=%h expected 1 %b %h", rsp_valid, rsp_id, rsp_data, e.id, e.data);
    else passed++;
    step();
    total++;
    if (exp_q.size() !== 0) $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size());
    else passed++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_add();
    test_sub_backpressure();
    test_contention();
    test_illegal();
    test_slt();
    test_reset_exec();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
